// File: rtl/demultiplexador_registrado.sv
// Registered 1-to-8 demux: steers one producer word into one of eight holding slots, one-cycle latency.
// Backpressure: entrada_pronta drops only while the addressed slot is full and not being drained this cycle.
module demultiplexador_registrado #(
  parameter int LARGURA = 16
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic [LARGURA-1:0]   entrada,
  input  logic [2:0]           controle,
  input  logic                 entrada_valida,
  output logic                 entrada_pronta,
  output logic [8*LARGURA-1:0] saidas,
  output logic [7:0]           saidas_validas,
  input  logic [7:0]           saidas_lidas,
  output logic [3:0]           ocupados
);

  logic       aceita;
  logic [7:0] aceita_vet;
  logic [7:0] drenos;
  logic [7:0] validas_prox;
  logic [3:0] n_drenos;
  logic [3:0] ocupados_prox;

  assign entrada_pronta = ~saidas_validas[controle] | saidas_lidas[controle];
  assign aceita         = entrada_valida & entrada_pronta;
  assign drenos         = saidas_lidas & saidas_validas;

  always_comb begin
    aceita_vet = 8'h00;
    n_drenos   = 4'd0;
    if (aceita) begin
      aceita_vet[controle] = 1'b1;
    end
    for (int k = 0; k < 8; k++) begin
      n_drenos = n_drenos + {3'b000, drenos[k]};
    end
    // A drain and an accept on the same slot cancel out: -1 from the drain, +1 from the accept.
    validas_prox  = (saidas_validas & ~drenos) | aceita_vet;
    ocupados_prox = ocupados + {3'b000, aceita} - n_drenos;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      saidas         <= '0;
      saidas_validas <= 8'h00;
      ocupados       <= 4'd0;
    end else begin
      saidas_validas <= validas_prox;
      ocupados       <= ocupados_prox;
      // Drained slots keep their data; only an accept overwrites a slot.
      for (int k = 0; k < 8; k++) begin
        if (aceita_vet[k]) begin
          saidas[k*LARGURA +: LARGURA] <= entrada;
        end
      end
    end
  end

endmodule

// File: tb/tb_demultiplexador_registrado.sv
// Bench for demultiplexador_registrado: directed scenarios plus random traffic against a slot-array model.
module tb_demultiplexador_registrado;

  logic         clock;
  logic         resetn;
  logic [15:0]  entrada;
  logic [2:0]   controle;
  logic         entrada_valida;
  logic         entrada_pronta;
  logic [127:0] saidas;
  logic [7:0]   saidas_validas;
  logic [7:0]   saidas_lidas;
  logic [3:0]   ocupados;

  int checks = 0;
  int erros  = 0;

  // Reference model: slot contents and occupied flags.
  logic [15:0] m_dat [8];
  bit          m_vld [8];

  demultiplexador_registrado #(.LARGURA(16)) dut (
    .clock          (clock),
    .resetn         (resetn),
    .entrada        (entrada),
    .controle       (controle),
    .entrada_valida (entrada_valida),
    .entrada_pronta (entrada_pronta),
    .saidas         (saidas),
    .saidas_validas (saidas_validas),
    .saidas_lidas   (saidas_lidas),
    .ocupados       (ocupados)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checa(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    checks++;
    if (obs !== esp) begin
      erros++;
      $display("FAIL %s: got %h expected %h", tag, obs, esp);
    end
  endtask

  task automatic modelo_reset();
    for (int k = 0; k < 8; k++) begin
      m_dat[k] = 16'h0000;
      m_vld[k] = 1'b0;
    end
  endtask

  function automatic logic [7:0] m_vetor();
    logic [7:0] v;
    v = 8'h00;
    for (int k = 0; k < 8; k++) v[k] = m_vld[k];
    return v;
  endfunction

  function automatic int m_conta();
    int n;
    n = 0;
    for (int k = 0; k < 8; k++) if (m_vld[k]) n++;
    return n;
  endfunction

  task automatic checa_estado();
    checa("saidas_validas", {24'h0, saidas_validas}, {24'h0, m_vetor()});
    checa("ocupados", {28'h0, ocupados}, m_conta());
    for (int k = 0; k < 8; k++) begin
      checa($sformatf("slot%0d", k), {16'h0, saidas[k*16 +: 16]}, {16'h0, m_dat[k]});
    end
  endtask

  // One transaction: drive at negedge, check ready, advance the model at posedge, check state after.
  task automatic passo(input logic v, input logic [2:0] c, input logic [15:0] d, input logic [7:0] l);
    bit pronta_esp;
    @(negedge clock);
    entrada_valida = v;
    controle       = c;
    entrada        = d;
    saidas_lidas   = l;
    #1;
    pronta_esp = !m_vld[c] || l[c];
    checa("entrada_pronta", {31'h0, entrada_pronta}, {31'h0, pronta_esp});
    @(posedge clock);
    for (int k = 0; k < 8; k++) if (l[k]) m_vld[k] = 1'b0;
    if (v && pronta_esp) begin
      m_dat[c] = d;
      m_vld[c] = 1'b1;
    end
    #1;
    checa_estado();
  endtask

  initial begin
    resetn         = 1'b0;
    entrada        = 16'h0000;
    controle       = 3'd0;
    entrada_valida = 1'b0;
    saidas_lidas   = 8'h00;
    modelo_reset();

    repeat (2) @(posedge clock);
    #1;
    checa("rst_validas", {24'h0, saidas_validas}, 32'h0);
    checa("rst_ocupados", {28'h0, ocupados}, 32'h0);
    @(negedge clock);
    resetn = 1'b1;

    // First write to slot 3.
    passo(1'b1, 3'd3, 16'hA5A5, 8'h00);
    checa("w3_validas", {24'h0, saidas_validas}, 32'h08);
    checa("w3_dado", {16'h0, saidas[3*16 +: 16]}, 32'hA5A5);
    checa("w3_ocupados", {28'h0, ocupados}, 32'h1);

    // Blocked write to a full slot.
    passo(1'b1, 3'd3, 16'h1234, 8'h00);
    checa("bloq_dado", {16'h0, saidas[3*16 +: 16]}, 32'hA5A5);
    checa("bloq_ocupados", {28'h0, ocupados}, 32'h1);

    // Drain and refill slot 3 in the same cycle.
    passo(1'b1, 3'd3, 16'h1234, 8'h08);
    checa("dr_dado", {16'h0, saidas[3*16 +: 16]}, 32'h1234);
    checa("dr_ocupados", {28'h0, ocupados}, 32'h1);

    // Empty slot 3, fill all slots, then drain all at once.
    passo(1'b0, 3'd0, 16'h0000, 8'h08);
    for (int k = 0; k < 8; k++) passo(1'b1, 3'(k), 16'(k), 8'h00);
    checa("cheio_ocupados", {28'h0, ocupados}, 32'h8);
    checa("cheio_validas", {24'h0, saidas_validas}, 32'hFF);
    passo(1'b0, 3'd0, 16'h0000, 8'hFF);
    checa("vazio_ocupados", {28'h0, ocupados}, 32'h0);
    checa("vazio_validas", {24'h0, saidas_validas}, 32'h00);
    for (int k = 0; k < 8; k++) checa("retido", {16'h0, saidas[k*16 +: 16]}, 32'(k));

    // Ack on an empty slot is ignored.
    passo(1'b1, 3'd5, 16'hBEEF, 8'h01);
    checa("ign_validas", {24'h0, saidas_validas}, 32'h20);
    checa("ign_ocupados", {28'h0, ocupados}, 32'h1);

    // Fill up, then assert reset asynchronously between edges.
    for (int k = 0; k < 8; k++) if (k != 5) passo(1'b1, 3'(k), 16'(16'h100 + k), 8'h00);
    @(negedge clock);
    entrada_valida = 1'b0;
    saidas_lidas   = 8'h00;
    #2;
    resetn = 1'b0;
    #1;
    checa("arst_validas", {24'h0, saidas_validas}, 32'h0);
    checa("arst_ocupados", {28'h0, ocupados}, 32'h0);
    checa("arst_slot5", {16'h0, saidas[5*16 +: 16]}, 32'h0);
    modelo_reset();
    @(negedge clock);
    resetn = 1'b1;
    passo(1'b1, 3'd7, 16'h00FF, 8'h00);
    checa("pos_validas", {24'h0, saidas_validas}, 32'h80);
    checa("pos_dado", {16'h0, saidas[7*16 +: 16]}, 32'h00FF);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      passo(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 16'($urandom),
            8'($urandom) & 8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, erros);
    $finish;
  end

endmodule

// File: doc/demultiplexador_registrado.md
Name: demultiplexador_registrado

Overview:
Registered 1-to-8 demultiplexer: the write-side counterpart of the 8:1 read multiplexer on the 16-bit datapath. One producer presents a word plus a 3-bit destination code; the block steers it into one of eight holding slots. Each slot has its own valid/acknowledge handshake toward its consumer (register-file load port, output latch, etc.). Also reports slot occupancy for the control unit.

Parameters:
LARGURA, 16, data width of input word and of each slot

Ports:
clock  input  1  system clock, all state updates on rising edge
resetn  input  1  reset, asynchronous, active-low
entrada  input  LARGURA  data word from producer
controle  input  3  destination slot index (0..7)
entrada_valida  input  1  producer has a word this cycle
entrada_pronta  output  1  block accepts the word this cycle (combinational)
saidas  output  8*LARGURA  slot contents, slot k at bits [k*LARGURA +: LARGURA]
saidas_validas  output  8  bit k = slot k holds an unconsumed word
saidas_lidas  input  8  bit k = consumer k takes slot k this cycle
ocupados  output  4  number of valid slots (0..8), registered

Behaviour:
- One clock (clock); reset is asynchronous and active-low (resetn). While resetn=0: all slots = 0, saidas_validas = 8'h00, ocupados = 0. Clearing takes effect immediately, not at the next edge. An in-flight accept is discarded.
- entrada_pronta = ~saidas_validas[controle] | saidas_lidas[controle]. It depends only on the addressed slot and is never gated by entrada_valida.
- Accept: entrada_valida & entrada_pronta. At the next edge, slot[controle] <= entrada and saidas_validas[controle] <= 1. Latency from accept to visible output is 1 cycle.
- Drain: saidas_lidas[k] & saidas_validas[k]. At the next edge, saidas_validas[k] <= 0. Slot data is retained, not cleared.
- saidas_lidas[k] on an empty slot: ignored, no state change.
- Simultaneous drain and accept on the same slot:
  - entrada_pronta = 1.
  - New data is written and valid stays 1.
  - ocupados is unchanged.
- Accepts and drains on other slots in the same cycle are independent. At most one accept per cycle; any number of drains.
- Occupied slot, no ack, entrada_valida = 1: entrada_pronta = 0. Nothing is written. The producer must hold entrada/controle stable until acceptance. The block does not check this.
- ocupados_next = ocupados + accept_into_empty_or_nondrained - drains_that_free_slot.
  - Arithmetic is 4-bit unsigned.
  - It must equal popcount(saidas_validas) at every edge.
  - Range is 0..8; it never wraps.
- No internal FSM beyond the eight per-slot valid flags. Each slot is a two-state EMPTY/FULL machine:
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY on drain without accept.
  - FULL -> FULL on drain plus accept, or on neither.
- saidas and saidas_validas are driven directly from flops and contain no combinational path from inputs.

Test Plan:
- Reset, then write 16'hA5A5 to slot 3:
  - Before reset release: saidas_validas = 0 and ocupados = 0.
  - On the cycle of the write: entrada_pronta = 1.
  - Next cycle: saidas_validas = 8'h08, slot 3 = A5A5, ocupados = 1.
- Write slot 3 again (16'h1234) with saidas_lidas = 0: entrada_pronta = 0. Slot 3 stays A5A5 and ocupados stays 1.
- Same cycle: write 16'h1234 to slot 3 and saidas_lidas = 8'h08. entrada_pronta = 1. Next cycle slot 3 = 1234, valid bit 3 = 1, ocupados = 1.
- Fill all 8 slots with values 16'h0000..16'h0007 on consecutive cycles, then ack 8'hFF in one cycle:
  - After the fill: ocupados = 8 and saidas_validas = FF.
  - One cycle after the ack: saidas_validas = 00, ocupados = 0, and slot data is still 0..7.
- Drive saidas_lidas = 8'h01 on an empty slot 0 while writing 16'hBEEF to slot 5: only bit 5 becomes set and ocupados = 1.
- Assert resetn = 0 mid-cycle with slots full: saidas_validas and ocupados go to 0 before the next clock edge. After release, the first write (16'h00FF to slot 7) behaves as after a fresh reset.
